// File: rtl/tia_playfield_scanner_pkg.sv
// Shared types and sizing helpers for the playfield scanner and its scan counter.
package tia_playfield_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } scan_state_t;

    localparam int DEF_PF_BITS     = 20;
    localparam int DEF_PIX_PER_BIT = 4;
    localparam int DEF_WR_W        = 8;

    function automatic int slice_count(input int pf_bits, input int wr_w);
        return (pf_bits + wr_w - 1) / wr_w;
    endfunction

    // A single-slice image still gets a one-bit address so the port never collapses to zero width.
    function automatic int addr_width(input int pf_bits, input int wr_w);
        int n;
        n = slice_count(pf_bits, wr_w);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tia_playfield_scanner_if.sv
// Write bus, scan control and pixel outputs of the playfield scanner.
interface tia_playfield_scanner_if
    import tia_playfield_pkg::*;
#(
    parameter int PF_BITS = DEF_PF_BITS,
    parameter int WR_W    = DEF_WR_W
) ();
    localparam int AW = addr_width(PF_BITS, WR_W);

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [WR_W-1:0] wr_data;
    logic          line_start;
    logic          pix_en;
    logic          reflect;
    logic          pf_out;
    logic          pf_side;
    logic          pf_active;

    modport master (
        output wr_en, wr_addr, wr_data, line_start, pix_en, reflect,
        input  pf_out, pf_side, pf_active
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, line_start, pix_en, reflect,
        output pf_out, pf_side, pf_active
    );
endinterface

// File: rtl/tia_playfield_scanner_scan_counter.sv
// Scan state machine: walks bit_idx/sub across the left half, then the right half.
module tia_playfield_scan_counter
    import tia_playfield_pkg::*;
#(
    parameter int PF_BITS     = DEF_PF_BITS,
    parameter int PIX_PER_BIT = DEF_PIX_PER_BIT,
    localparam int IW = (PF_BITS <= 1) ? 1 : $clog2(PF_BITS),
    localparam int SW = (PIX_PER_BIT <= 1) ? 1 : $clog2(PIX_PER_BIT)
) (
    input  logic          clk,
    input  logic          rst_l,
    input  logic          line_start,
    input  logic          pix_en,
    input  logic          reflect,
    output scan_state_t   state,
    output logic [IW-1:0] bit_idx,
    output logic          reflect_latch
);
    localparam logic [SW-1:0] SUB_LAST = SW'(PIX_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_LAST = IW'(PF_BITS - 1);

    scan_state_t   state_reg;
    logic [IW-1:0] bit_idx_reg;
    logic [SW-1:0] sub_reg;
    logic          reflect_latch_reg;

    // line_start outranks pix_en so a restart always lands cleanly on bit 0.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_reg         <= ST_IDLE;
            bit_idx_reg       <= '0;
            sub_reg           <= '0;
            reflect_latch_reg <= 1'b0;
        end else if (line_start) begin
            state_reg   <= ST_LEFT;
            bit_idx_reg <= '0;
            sub_reg     <= '0;
        end else if (pix_en && state_reg != ST_IDLE) begin
            if (sub_reg == SUB_LAST) begin
                sub_reg <= '0;
                if (bit_idx_reg == BIT_LAST) begin
                    bit_idx_reg <= '0;
                    if (state_reg == ST_LEFT) begin
                        state_reg         <= ST_RIGHT;
                        reflect_latch_reg <= reflect;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end else begin
                    bit_idx_reg <= bit_idx_reg + 1'b1;
                end
            end else begin
                sub_reg <= sub_reg + 1'b1;
            end
        end
    end

    assign state         = state_reg;
    assign bit_idx       = bit_idx_reg;
    assign reflect_latch = reflect_latch_reg;

endmodule

// File: rtl/tia_playfield_scanner.sv
// Playfield image registers with slice writes, optional shadow commit and scan output mux.
module tia_playfield_scanner
    import tia_playfield_pkg::*;
#(
    parameter int PF_BITS     = DEF_PF_BITS,
    parameter int PIX_PER_BIT = DEF_PIX_PER_BIT,
    parameter int WR_W        = DEF_WR_W,
    parameter int DOUBLE_BUF  = 1
) (
    input  logic clk,
    input  logic rst_l,
    tia_playfield_scanner_if.slave bus
);
    localparam int AW = addr_width(PF_BITS, WR_W);
    localparam int IW = (PF_BITS <= 1) ? 1 : $clog2(PF_BITS);

    logic [PF_BITS-1:0] wr_hit;
    logic [PF_BITS-1:0] wr_val;
    logic [PF_BITS-1:0] active_reg;
    scan_state_t        state;
    logic [IW-1:0]      bit_idx;
    logic [IW-1:0]      eff_idx;
    logic               reflect_latch;

    // Per-bit decode: addresses past the last slice match no bit, so those writes vanish.
    genvar gi;
    generate
        for (gi = 0; gi < PF_BITS; gi++) begin : g_wr
            assign wr_hit[gi] = bus.wr_en && (bus.wr_addr == AW'(gi / WR_W));
            assign wr_val[gi] = bus.wr_data[gi % WR_W];
        end
    endgenerate

    generate
        if (DOUBLE_BUF != 0) begin : g_dbuf
            logic [PF_BITS-1:0] shadow_reg;
            logic [PF_BITS-1:0] shadow_next;

            // Commit takes the already-merged shadow so a same-cycle write is not lost.
            assign shadow_next = (shadow_reg & ~wr_hit) | (wr_val & wr_hit);

            always_ff @(posedge clk or negedge rst_l) begin
                if (!rst_l) begin
                    shadow_reg <= '0;
                    active_reg <= '0;
                end else begin
                    shadow_reg <= shadow_next;
                    if (bus.line_start)
                        active_reg <= shadow_next;
                end
            end
        end else begin : g_direct
            always_ff @(posedge clk or negedge rst_l) begin
                if (!rst_l)
                    active_reg <= '0;
                else
                    active_reg <= (active_reg & ~wr_hit) | (wr_val & wr_hit);
            end
        end
    endgenerate

    tia_playfield_scan_counter #(
        .PF_BITS     (PF_BITS),
        .PIX_PER_BIT (PIX_PER_BIT)
    ) u_counter (
        .clk           (clk),
        .rst_l         (rst_l),
        .line_start    (bus.line_start),
        .pix_en        (bus.pix_en),
        .reflect       (bus.reflect),
        .state         (state),
        .bit_idx       (bit_idx),
        .reflect_latch (reflect_latch)
    );

    always_comb begin
        eff_idx = bit_idx;
        if (state == ST_RIGHT && reflect_latch)
            eff_idx = IW'(PF_BITS - 1) - bit_idx;
    end

    assign bus.pf_out    = (state != ST_IDLE) && active_reg[eff_idx];
    assign bus.pf_side   = (state == ST_RIGHT);
    assign bus.pf_active = (state != ST_IDLE);

endmodule

// File: tb/tb_tia_playfield_scanner.sv
// Directed bench: double-buffered and direct-write scanners driven side by side against a position-based model.
module tb_tia_playfield_scanner;
    localparam int PFB = 20;
    localparam int PPB = 4;
    localparam int WW  = 8;
    localparam int L   = PFB * PPB;
    localparam int NT  = 2 * L;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       line_start = 1'b0;
    logic       pix_en = 1'b0;
    logic       reflect = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tia_playfield_scanner_if #(.PF_BITS(PFB), .WR_W(WW)) bus_db ();
    tia_playfield_scanner_if #(.PF_BITS(PFB), .WR_W(WW)) bus_nb ();

    assign bus_db.wr_en = wr_en;  assign bus_db.wr_addr = wr_addr;  assign bus_db.wr_data = wr_data;
    assign bus_db.line_start = line_start;  assign bus_db.pix_en = pix_en;  assign bus_db.reflect = reflect;
    assign bus_nb.wr_en = wr_en;  assign bus_nb.wr_addr = wr_addr;  assign bus_nb.wr_data = wr_data;
    assign bus_nb.line_start = line_start;  assign bus_nb.pix_en = pix_en;  assign bus_nb.reflect = reflect;

    tia_playfield_scanner #(.PF_BITS(PFB), .PIX_PER_BIT(PPB), .WR_W(WW), .DOUBLE_BUF(1)) dut_db (
        .clk(clk), .rst_l(rst_l), .bus(bus_db.slave));
    tia_playfield_scanner #(.PF_BITS(PFB), .PIX_PER_BIT(PPB), .WR_W(WW), .DOUBLE_BUF(0)) dut_nb (
        .clk(clk), .rst_l(rst_l), .bus(bus_nb.slave));

    task automatic chk(input string nm, input logic act, input logic exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: position within the line (-1 = idle), images as plain bit vectors.
    int               m_pos = -1;
    logic             m_refl = 1'b0;
    logic [PFB-1:0]   m_sh_db = '0;
    logic [PFB-1:0]   m_act_db = '0;
    logic [PFB-1:0]   m_act_nb = '0;

    function automatic logic [PFB-1:0] merge(input logic [PFB-1:0] img, input logic en,
                                             input int addr, input logic [WW-1:0] data);
        logic [PFB-1:0] r;
        r = img;
        if (en)
            for (int b = 0; b < PFB; b++)
                if (b / WW == addr) r[5'(b)] = data[3'(b % WW)];
        return r;
    endfunction

    function automatic logic exp_out(input logic [PFB-1:0] img, input int pos, input logic refl);
        int bitn;
        if (pos < 0) return 1'b0;
        bitn = (pos % L) / PPB;
        if (pos >= L && refl) bitn = PFB - 1 - bitn;
        return img[5'(bitn)];
    endfunction

    always @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            m_pos    <= -1;
            m_refl   <= 1'b0;
            m_sh_db  <= '0;
            m_act_db <= '0;
            m_act_nb <= '0;
        end else begin
            m_sh_db  <= merge(m_sh_db, wr_en, int'(wr_addr), wr_data);
            m_act_nb <= merge(m_act_nb, wr_en, int'(wr_addr), wr_data);
            if (line_start) begin
                m_act_db <= merge(m_sh_db, wr_en, int'(wr_addr), wr_data);
                m_pos    <= 0;
            end else if (pix_en && m_pos >= 0) begin
                m_pos <= (m_pos == NT - 1) ? -1 : m_pos + 1;
                if (m_pos == L - 1) m_refl <= reflect;
            end
        end
    end

    always @(negedge clk) begin
        chk("mdl_db.pf_out",    bus_db.pf_out,    exp_out(m_act_db, m_pos, m_refl));
        chk("mdl_db.pf_side",   bus_db.pf_side,   m_pos >= L);
        chk("mdl_db.pf_active", bus_db.pf_active, m_pos >= 0);
        chk("mdl_nb.pf_out",    bus_nb.pf_out,    exp_out(m_act_nb, m_pos, m_refl));
        chk("mdl_nb.pf_side",   bus_nb.pf_side,   m_pos >= L);
        chk("mdl_nb.pf_active", bus_nb.pf_active, m_pos >= 0);
    end

    logic cap_o [2][NT+1];
    logic cap_s [2][NT+1];
    logic cap_a [2][NT+1];

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic sample(input int k);
        cap_o[0][k] = bus_db.pf_out;  cap_s[0][k] = bus_db.pf_side;  cap_a[0][k] = bus_db.pf_active;
        cap_o[1][k] = bus_nb.pf_out;  cap_s[1][k] = bus_nb.pf_side;  cap_a[1][k] = bus_nb.pf_active;
    endtask

    task automatic write_slice(input int a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = 2'(a); wr_data = d;
        step();
        wr_en = 1'b0;
        $display("write addr=%0d data=0x%02h", a, d);
    endtask

    // One full line; optional write just before tick wr_tick and reflect toggling over ticks 90-100.
    task automatic run_line(input string nm, input int gap, input int wr_tick, input int wa,
                            input logic [7:0] wd, input bit refl_toggle);
        int k;
        int cyc;
        line_start = 1'b1;
        step();
        line_start = 1'b0;
        sample(0);
        k = 0;
        cyc = 0;
        while (k < NT) begin
            pix_en = (cyc % gap == 0);
            cyc++;
            if (pix_en && k + 1 == wr_tick) begin
                wr_en = 1'b1; wr_addr = 2'(wa); wr_data = wd;
            end
            if (refl_toggle && pix_en && k + 1 >= 90 && k + 1 <= 100) reflect = ~reflect;
            step();
            wr_en = 1'b0;
            if (pix_en) begin
                k++;
                sample(k);
            end
        end
        pix_en = 1'b0;
        $display("line %s gap=%0d cycles=%0d", nm, gap, cyc);
    endtask

    task automatic check_pat(input string nm, input int d, input int a0, input int a1,
                             input int b0, input int b1);
        for (int k = 0; k <= NT; k++) begin
            chk($sformatf("%s.d%0d.out[%0d]", nm, d, k), cap_o[d][k],
                (k >= a0 && k <= a1) || (k >= b0 && k <= b1));
        end
    endtask

    task automatic check_side(input string nm);
        for (int d = 0; d < 2; d++)
            for (int k = 0; k <= NT; k++) begin
                chk($sformatf("%s.d%0d.side[%0d]", nm, d, k), cap_s[d][k], k >= L && k < NT);
                chk($sformatf("%s.d%0d.act[%0d]", nm, d, k), cap_a[d][k], k < NT);
            end
    endtask

    initial begin
        step();
        step();
        chk("rst.db.pf_out", bus_db.pf_out, 1'b0);
        chk("rst.db.pf_side", bus_db.pf_side, 1'b0);
        chk("rst.db.pf_active", bus_db.pf_active, 1'b0);
        chk("rst.nb.pf_active", bus_nb.pf_active, 1'b0);
        rst_l = 1'b1;
        step();

        run_line("blank", 1, -1, 0, 8'h00, 1'b0);
        check_pat("blank", 0, -1, -2, -1, -2);
        check_pat("blank", 1, -1, -2, -1, -2);
        check_side("blank");

        write_slice(0, 8'h01);
        run_line("repeat", 1, -1, 0, 8'h00, 1'b0);
        check_pat("repeat", 0, 0, 3, 80, 83);
        check_pat("repeat", 1, 0, 3, 80, 83);
        check_side("repeat");

        reflect = 1'b1;
        run_line("reflect", 1, -1, 0, 8'h00, 1'b1);
        reflect = 1'b0;
        check_pat("reflect", 0, 0, 3, 156, 159);
        check_pat("reflect", 1, 0, 3, 156, 159);

        write_slice(0, 8'h00);
        write_slice(2, 8'hFF);
        run_line("slice2", 1, -1, 0, 8'h00, 1'b0);
        check_pat("slice2", 0, 64, 79, 144, 159);
        check_pat("slice2", 1, 64, 79, 144, 159);
        write_slice(3, 8'hAA);
        run_line("slice3", 1, -1, 0, 8'h00, 1'b0);
        check_pat("slice3", 0, 64, 79, 144, 159);
        check_pat("slice3", 1, 64, 79, 144, 159);

        write_slice(2, 8'h00);
        run_line("dbuf_mid", 1, 41, 1, 8'hFF, 1'b0);
        check_pat("dbuf_mid", 0, -1, -2, -1, -2);
        check_pat("dbuf_mid", 1, 41, 63, 112, 143);
        run_line("dbuf_next", 1, -1, 0, 8'h00, 1'b0);
        check_pat("dbuf_next", 0, 32, 63, 112, 143);
        check_pat("dbuf_next", 1, 32, 63, 112, 143);

        run_line("stall", 3, -1, 0, 8'h00, 1'b0);
        check_pat("stall", 0, 32, 63, 112, 143);
        check_pat("stall", 1, 32, 63, 112, 143);
        check_side("stall");

        line_start = 1'b1;
        step();
        line_start = 1'b0;
        pix_en = 1'b1;
        repeat (50) step();
        chk("restart.pre.pf_out", bus_db.pf_out, 1'b1);
        line_start = 1'b1;
        step();
        line_start = 1'b0;
        chk("restart.pf_out", bus_db.pf_out, 1'b0);
        chk("restart.pf_side", bus_db.pf_side, 1'b0);
        chk("restart.pf_active", bus_db.pf_active, 1'b1);
        repeat (32) step();
        chk("restart.bit8.pf_out", bus_db.pf_out, 1'b1);
        chk("restart.bit8.nb.pf_out", bus_nb.pf_out, 1'b1);
        pix_en = 1'b0;
        $display("restart checked");

        line_start = 1'b1;
        step();
        line_start = 1'b0;
        pix_en = 1'b1;
        repeat (30) step();
        rst_l = 1'b0;
        #1;
        chk("midrst.db.pf_out", bus_db.pf_out, 1'b0);
        chk("midrst.db.pf_side", bus_db.pf_side, 1'b0);
        chk("midrst.db.pf_active", bus_db.pf_active, 1'b0);
        chk("midrst.nb.pf_active", bus_nb.pf_active, 1'b0);
        pix_en = 1'b0;
        step();
        step();
        rst_l = 1'b1;
        step();
        $display("mid-scan reset applied");

        run_line("post_rst", 1, -1, 0, 8'h00, 1'b0);
        check_pat("post_rst", 0, -1, -2, -1, -2);
        check_pat("post_rst", 1, -1, -2, -1, -2);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tia_playfield_scanner.md
Name: tia_playfield_scanner

Overview:
- Parametrised successor to the per-bit playfield register cell.
- Holds a PF_BITS-wide playfield image, loaded by CPU-style slice writes, optionally double-buffered.
- Scans the image serially across the left and right screen halves; the right half either repeats or reflects the image.
- Replaces the biphase-clocked cell chain with one clock, a pixel enable and an explicit scan state machine.

Parameters:
- PF_BITS, 20, playfield bits per half-line (1..64).
- PIX_PER_BIT, 4, pix_en ticks each bit is held (1..16).
- WR_W, 8, write slice width.
- DOUBLE_BUF, 1, 1: writes go to a shadow register committed at line_start; 0: writes go straight to the active register.

Ports:
- clk  in  1  system clock.
- rst_l  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe.
- wr_addr  in  clog2(ceil(PF_BITS/WR_W))  slice index; slice n = bits [n*WR_W +: WR_W].
- wr_data  in  WR_W  slice data; bit k maps to playfield bit n*WR_W+k.
- line_start  in  1  one-cycle pulse; starts a scan line.
- pix_en  in  1  pixel-clock enable.
- reflect  in  1  right-half mirror request.
- pf_out  out  1  playfield pixel.
- pf_side  out  1  0 = left half, 1 = right half (score colouring).
- pf_active  out  1  scan in progress.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-scan):
  - active and shadow registers clear to 0.
  - State = IDLE, counters = 0, reflect latch = 0.
  - pf_out = pf_side = pf_active = 0.
- Writes:
  - On a wr_en cycle the addressed slice is updated at the clock edge.
  - Bits of the last slice at or above PF_BITS are dropped.
  - Writes with wr_addr beyond the last slice are ignored.
  - DOUBLE_BUF=0: the write updates active and is visible on pf_out the next cycle, even mid-scan.
- Commit (DOUBLE_BUF=1): on line_start, active <= shadow. A write in the same cycle is merged first; the write wins.
- States: IDLE, LEFT, RIGHT.
  - Counters: bit_idx (0..PF_BITS-1) and sub (0..PIX_PER_BIT-1).
  - line_start from any state: go to LEFT, bit_idx = 0, sub = 0. Any same-cycle pix_en is ignored, so line_start wins and a mid-scan restart is clean.
  - pix_en in LEFT/RIGHT: sub++. When sub wraps, bit_idx++.
  - When bit_idx = PF_BITS-1 and sub wraps:
    - LEFT -> RIGHT: capture reflect into the latch, bit_idx = 0.
    - RIGHT -> IDLE.
  - pix_en in IDLE has no effect.
  - No pix_en: all state holds.
- Outputs (combinational from registered state and active):
  - Effective index: eff = bit_idx in LEFT; eff = reflect_latch ? PF_BITS-1-bit_idx : bit_idx in RIGHT.
  - pf_out = active[eff] when not IDLE, else 0.
  - pf_side = (state == RIGHT).
  - pf_active = (state != IDLE).
- Latency:
  - line_start at edge t: pf_out shows active[0] after edge t.
  - A full line takes 2*PF_BITS*PIX_PER_BIT pix_en ticks.
- reflect changes during the right half do not alter the scan; it is sampled only at the half boundary.

Decomposition:
- Shared package tia_playfield_pkg holds:
  - the state enum (IDLE/LEFT/RIGHT);
  - default PF_BITS / PIX_PER_BIT / WR_W constants;
  - the slice-count function ceil(PF_BITS/WR_W).
- One natural sub-module, tia_playfield_scan_counter: the sub/bit_idx counters and state FSM, emitting state and bit_idx.
- The top level holds the registers, write decode, commit and output mux.

Test Plan (defaults PF_BITS=20, PIX_PER_BIT=4, WR_W=8):
- Reset: hold rst_l=0 -> pf_out=pf_side=pf_active=0. Release, then line_start with no writes -> pf_out=0 for all 160 ticks; pf_active drops after tick 160.
- Repeat: write addr0=0x01, line_start, pix_en every cycle -> pf_out=1 on ticks 0-3 and 80-83 only; pf_side=1 on ticks 80-159.
- Reflect: same image, reflect=1 before tick 80, toggled during ticks 90-100 -> pf_out=1 on ticks 0-3 and 156-159 only.
- Slice edges: write addr2=0xFF -> only bits 16-19 set (ticks 64-79 high). Write addr3 -> no change.
- Double-buffer: DOUBLE_BUF=1, write addr1=0xFF mid-line -> current line unchanged, next line ticks 32-63 high. DOUBLE_BUF=0 -> change visible the next cycle.
- Stall and restart: pix_en gapped 1-in-3 -> each bit held 4 enabled ticks. line_start at tick 50 -> restart at bit 0 in LEFT. rst_l low at tick 30 -> all outputs 0 immediately.
